// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Bubbles (flush or load-use stall) zero every EX field; invalid ID words pass through as-is.
module id_ex_stage #(
    parameter int unsigned BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_RegWrite,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic [4:0]        id_ALUOp,
    input  logic [2:0]        id_NPCOp,
    input  logic [2:0]        id_DMType,
    input  logic [1:0]        id_WDSel,
    input  logic              flush,

    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_RegWrite,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic [4:0]        ex_ALUOp,
    output logic [2:0]        ex_NPCOp,
    output logic [2:0]        ex_DMType,
    output logic [1:0]        ex_WDSel,

    output logic              hazard_stall,
    output logic [BCNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] WdselMem = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic [4:0]  alu_op;
        logic [2:0]  npc_op;
        logic [2:0]  dm_type;
        logic [1:0]  wd_sel;
    } ex_word_t;

    ex_word_t    id_word;
    ex_word_t    ex_d, ex_q;
    logic [BCNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    logic load_in_ex;
    logic rs1_dep;
    logic rs2_dep;
    logic hazard;
    logic insert_bubble;

    always_comb begin
        id_word           = '0;
        id_word.valid     = id_valid;
        id_word.pc        = id_pc;
        id_word.rs1_data  = id_rs1_data;
        id_word.rs2_data  = id_rs2_data;
        id_word.imm       = id_imm;
        id_word.rs1       = id_rs1;
        id_word.rs2       = id_rs2;
        id_word.rd        = id_rd;
        id_word.reg_write = id_RegWrite;
        id_word.mem_write = id_MemWrite;
        id_word.alu_src   = id_ALUSrc;
        id_word.alu_op    = id_ALUOp;
        id_word.npc_op    = id_NPCOp;
        id_word.dm_type   = id_DMType;
        id_word.wd_sel    = id_WDSel;
    end

    // Only a load in EX can't forward in time; x0 is never a real dependency.
    always_comb begin
        load_in_ex    = ex_q.valid && (ex_q.wd_sel == WdselMem) && (ex_q.rd != 5'd0);
        rs1_dep       = id_rs1_used && (id_rs1 == ex_q.rd);
        rs2_dep       = id_rs2_used && (id_rs2 == ex_q.rd);
        hazard        = load_in_ex && id_valid && (rs1_dep || rs2_dep);
        insert_bubble = flush || hazard;
        // A flush kills the ID instruction, so there is nothing left to hold upstream.
        hazard_stall  = hazard && !flush;
    end

    always_comb begin
        ex_d         = insert_bubble ? '0 : id_word;
        bubble_cnt_d = bubble_cnt_q;
        if (insert_bubble && (bubble_cnt_q != {BCNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    always_comb begin
        ex_valid    = ex_q.valid;
        ex_pc       = ex_q.pc;
        ex_rs1_data = ex_q.rs1_data;
        ex_rs2_data = ex_q.rs2_data;
        ex_imm      = ex_q.imm;
        ex_rs1      = ex_q.rs1;
        ex_rs2      = ex_q.rs2;
        ex_rd       = ex_q.rd;
        ex_RegWrite = ex_q.reg_write;
        ex_MemWrite = ex_q.mem_write;
        ex_ALUSrc   = ex_q.alu_src;
        ex_ALUOp    = ex_q.alu_op;
        ex_NPCOp    = ex_q.npc_op;
        ex_DMType   = ex_q.dm_type;
        ex_WDSel    = ex_q.wd_sel;
        bubble_cnt  = bubble_cnt_q;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage core, with load-use hazard detection and a saturating bubble counter. Captures the decoded control word and register-file operands from the ID stage every cycle, and presents them to EX on the following cycle. Detects a load in EX whose destination is a source of the instruction in ID, and then stalls PC and IF/ID while inserting a bubble. Honours a flush from EX branch/jump resolution.

## Interface
- BCNT_W, default 16: width of the bubble counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_used, id_rs2_used  in  1 each  the instruction actually reads that source.
- id_RegWrite, id_MemWrite, id_ALUSrc  in  1 each  decoder controls.
- id_ALUOp  in  5  decoder control.
- id_NPCOp  in  3  decoder control.
- id_DMType  in  3  decoder control.
- id_WDSel  in  2  decoder control; 01 = memory (load).
- flush  in  1  EX redirect; kills the ID instruction.
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_DMType, ex_WDSel  out  same widths as the id_ counterparts  registered EX copies.
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt  out  BCNT_W  saturating count of inserted bubbles (stall + flush).

## Operation
- Load-use hazard, combinational:
  - load_in_ex = ex_valid & (ex_WDSel == 2'b01) & (ex_rd != 0).
  - hazard = load_in_ex & id_valid & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
  - hazard_stall = hazard & ~flush.
- Register update at each rising edge, in priority order:
  - flush: load bubble.
  - else hazard: load bubble. The ID instruction is held upstream and is re-presented next cycle.
  - else: load every ex_ field from its id_ counterpart, with ex_valid = id_valid.
- Bubble: every ex_ output is 0, including ex_valid and all control and data fields. A bubble therefore writes nothing and never redirects.
- An invalid ID instruction is not forced to a bubble. Its fields pass through with ex_valid = 0. Downstream gates on ex_valid.
- bubble_cnt increments by 1 on every edge that loads a bubble due to flush or hazard. It holds at 2^BCNT_W−1.
- No x0 special-casing beyond the hazard check. ex_rd = 0 with RegWrite = 1 passes unchanged.

## Timing
- Reset (async, active-high): all ex_ outputs 0, bubble_cnt 0. hazard_stall evaluates to 0 because ex_valid = 0.
- Latency: 1 cycle from ID to EX.
- hazard_stall is purely combinational from the current ex_ registers and the id_ inputs, with no registered delay. A stall lasts exactly 1 cycle per load-use pair: the following cycle ex_valid = 0, so the hazard clears.
- Simultaneous flush and hazard: bubble is inserted, hazard_stall = 0 (the wrong-path ID instruction is dropped), and bubble_cnt increments once.
- Back-to-back loads, each dependent on the previous: a stall occurs on each pair, with no merging.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads normally.

## Test plan
- Reset:
  - Stimulus: assert rst with arbitrary id_ inputs.
  - Required: all ex_ outputs 0, bubble_cnt = 0, hazard_stall = 0.
  - Release, then present add x3,x1,x2 with pc = 0x100.
  - Required: next cycle ex_pc = 0x100, ex_rd = 3, ex_ALUOp equal to the input value, ex_valid = 1.
- Load-use:
  - Stimulus: EX holds lw x5 (WDSel = 01, rd = 5); ID holds add x6,x5,x1 with rs1_used = 1.
  - Required: hazard_stall = 1 in that cycle. Next cycle all ex_ are 0 and bubble_cnt = 1. The held add then enters EX with hazard_stall = 0.
- No-hazard cases:
  - lw x5 followed by add using rs2 = 5 with rs2_used = 0 → hazard_stall = 0.
  - lw x0 followed by add using x0 → hazard_stall = 0.
  - addi x5 in EX (WDSel = 00) → hazard_stall = 0.
- Flush:
  - Stimulus: flush = 1 with a valid ID instruction.
  - Required: next cycle ex_valid = 0, ex_NPCOp = 0, ex_MemWrite = 0, bubble_cnt += 1.
  - Stimulus: flush and hazard together.
  - Required: hazard_stall = 0, one bubble, bubble_cnt += 1.
- Saturation:
  - Stimulus: BCNT_W = 4; drive flush for 20 consecutive cycles.
  - Required: bubble_cnt reaches 15 and holds. rst then clears it to 0 asynchronously.
